// File: rtl/mio_pkg.sv
// Shared types and constants for the memory-mapped I/O bridge.
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] GFX_BASE    = 32'hA000_0000;
    localparam logic [31:0] SEG_BASE    = 32'hE000_0000;
    localparam logic [31:0] GPIO_BASE   = 32'hF000_0000;
    localparam logic [31:0] REGION_MASK = 32'hF000_0000;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/mio_bus_bridge_if.sv
// CPU data-port and slave-side signals of the bridge, bundled with both views.
interface mio_bus_if #(
    parameter int N_SLV = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                mem_w;
    logic                mem_rd;
    logic [AW-1:0]       addr_bus;
    logic [DW-1:0]       Cpu_data2bus;
    logic [DW-1:0]       Cpu_data4bus;
    logic                bus_ready;
    logic                bus_err;
    logic [N_SLV-1:0]    slv_sel;
    logic                slv_we;
    logic [AW-1:0]       slv_addr;
    logic [DW-1:0]       slv_wdata;
    logic [N_SLV*DW-1:0] slv_rdata;
    logic [N_SLV-1:0]    slv_ready;

    // Bridge view.
    modport slave (
        input  mem_w, mem_rd, addr_bus, Cpu_data2bus, slv_rdata, slv_ready,
        output Cpu_data4bus, bus_ready, bus_err, slv_sel, slv_we, slv_addr, slv_wdata
    );

    // CPU plus peripherals view.
    modport master (
        output mem_w, mem_rd, addr_bus, Cpu_data2bus, slv_rdata, slv_ready,
        input  Cpu_data4bus, bus_ready, bus_err, slv_sel, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/mio_addr_decode.sv
// Combinational base/mask region decoder; lowest matching index wins.
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int                  N_SLV    = 4,
    parameter int                  AW       = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0]    addr,
    output logic             hit,
    output logic [N_SLV-1:0] onehot
);

    // Base bits outside the mask are ignored so an all-zero mask matches everything.
    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (!hit && ((addr & SLV_MASK[i*AW +: AW]) ==
                         (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
                hit       = 1'b1;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mio_bus_bridge.sv
// Registered MMIO bridge: decode, wait-state handshake, timeout and bus-error reporting.
module mio_bus_bridge
    import mio_pkg::*;
#(
    parameter int                  N_SLV    = 4,
    parameter int                  AW       = 32,
    parameter int                  DW       = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {GPIO_BASE, SEG_BASE, GFX_BASE, RAM_BASE},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {4{REGION_MASK}},
    parameter int                  TIMEOUT  = 15,
    parameter int                  TO_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mio_bus_if.slave             bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t           state;
    logic [TO_W-1:0]  to_cnt;
    logic             is_wr;
    logic             req;
    logic             hit;
    logic [N_SLV-1:0] hit_vec;
    logic [AW-1:0]    hit_mask;
    logic             sel_ready;
    logic [DW-1:0]    sel_rdata;

    assign req = bus.mem_w | bus.mem_rd;

    mio_addr_decode #(
        .N_SLV   (N_SLV),
        .AW      (AW),
        .SLV_BASE(SLV_BASE),
        .SLV_MASK(SLV_MASK)
    ) u_decode (
        .addr  (bus.addr_bus),
        .hit   (hit),
        .onehot(hit_vec)
    );

    always_comb begin
        hit_mask  = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (hit_vec[i])
                hit_mask = hit_mask | SLV_MASK[i*AW +: AW];
            if (bus.slv_sel[i]) begin
                sel_ready = sel_ready | bus.slv_ready[i];
                sel_rdata = sel_rdata | bus.slv_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            to_cnt           <= '0;
            is_wr            <= 1'b0;
            err_cnt          <= '0;
            bus.Cpu_data4bus <= '0;
            bus.bus_ready    <= 1'b0;
            bus.bus_err      <= 1'b0;
            bus.slv_sel      <= '0;
            bus.slv_we       <= 1'b0;
            bus.slv_addr     <= '0;
            bus.slv_wdata    <= '0;
        end else begin
            bus.bus_ready <= 1'b0;
            bus.bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        // Simultaneous read and write requests resolve to a write.
                        is_wr <= bus.mem_w;
                        if (hit) begin
                            bus.slv_sel   <= hit_vec;
                            bus.slv_we    <= bus.mem_w;
                            bus.slv_addr  <= bus.addr_bus & ~hit_mask;
                            bus.slv_wdata <= bus.Cpu_data2bus;
                            to_cnt        <= '0;
                            state         <= ACCESS;
                        end else begin
                            bus.bus_ready <= 1'b1;
                            bus.bus_err   <= 1'b1;
                            err_cnt       <= err_cnt_inc(err_cnt);
                            if (!bus.mem_w)
                                bus.Cpu_data4bus <= '0;
                            state <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        if (!is_wr)
                            bus.Cpu_data4bus <= sel_rdata;
                        bus.slv_sel   <= '0;
                        bus.slv_we    <= 1'b0;
                        bus.bus_ready <= 1'b1;
                        state         <= RESP;
                    end else if (to_cnt == TO_W'(TIMEOUT)) begin
                        if (!is_wr)
                            bus.Cpu_data4bus <= '0;
                        bus.slv_sel   <= '0;
                        bus.slv_we    <= 1'b0;
                        bus.bus_ready <= 1'b1;
                        bus.bus_err   <= 1'b1;
                        err_cnt       <= err_cnt_inc(err_cnt);
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Scoreboard bench for mio_bus_bridge: stimulus pushes expectations, monitors pop and compare.
module tb_mio_bus_bridge;
    import mio_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] err_cnt;
    logic [7:0] err_cnt_p;

    mio_bus_if #(.N_SLV(4), .AW(32), .DW(32)) bus ();
    mio_bus_if #(.N_SLV(4), .AW(32), .DW(32)) bus_p ();

    localparam logic [127:0] PRIO_MASK = {32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000};

    mio_bus_bridge #(.N_SLV(4), .AW(32), .DW(32), .TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_cnt(err_cnt)
    );

    mio_bus_bridge #(.N_SLV(4), .AW(32), .DW(32), .SLV_MASK(PRIO_MASK), .TIMEOUT(15), .TO_W(4)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p), .err_cnt(err_cnt_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic        chk_data;
        logic [31:0] data;
        logic [7:0]  ecnt;
        int          req_cyc;
        int          lat;
        string       name;
    } rsp_t;

    typedef struct {
        logic [3:0]  sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cycles;
    } slv_t;

    rsp_t rq[$];
    slv_t sq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   wait_cfg = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (bus.bus_ready === 1'b1) begin
            if (rq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_bus_ready: got bus_ready=1 expected no response (cyc %0d)", cyc);
            end else begin
                rsp_t e;
                e = rq.pop_front();
                check({e.name, "_err"}, 32'(bus.bus_err), 32'(e.err));
                check({e.name, "_lat"}, 32'(cyc - e.req_cyc + 1), 32'(e.lat));
                check({e.name, "_errcnt"}, 32'(err_cnt), 32'(e.ecnt));
                if (e.chk_data)
                    check({e.name, "_rdata"}, bus.Cpu_data4bus, e.data);
            end
        end
    end

    // Slave model (ready after wait_cfg selected cycles) and slave-side monitor.
    int   s_cnt = 0;
    int   m_cnt = 0;
    logic s_act = 1'b0;
    logic s_ok  = 1'b0;
    slv_t s_exp;
    always @(negedge clk) begin
        if (bus.slv_sel != '0) begin
            bus.slv_ready = (s_cnt == wait_cfg) ? bus.slv_sel : 4'b0000;
            s_cnt++;
        end else begin
            bus.slv_ready = '0;
            s_cnt = 0;
        end

        if (bus.slv_sel != '0) begin
            if (!s_act) begin
                s_act = 1'b1;
                m_cnt = 1;
                if (sq.size() == 0) begin
                    s_ok = 1'b0;
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_select: got slv_sel=%b expected 0000", bus.slv_sel);
                end else begin
                    s_ok  = 1'b1;
                    s_exp = sq.pop_front();
                    check("slv_sel", 32'(bus.slv_sel), 32'(s_exp.sel));
                    check("slv_we", 32'(bus.slv_we), 32'(s_exp.we));
                    check("slv_addr", bus.slv_addr, s_exp.addr);
                    check("slv_wdata", bus.slv_wdata, s_exp.wdata);
                end
            end else begin
                m_cnt++;
                if (s_ok)
                    check("slv_hold", {27'd0, bus.slv_sel, bus.slv_we}, {27'd0, s_exp.sel, s_exp.we});
            end
        end else if (s_act) begin
            s_act = 1'b0;
            if (s_ok)
                check("slv_cycles", 32'(m_cnt), 32'(s_exp.cycles));
        end
    end

    task automatic access(input string name, input logic w, input logic r,
                          input logic [31:0] addr, input logic [31:0] wdata, input int wt,
                          input logic sel_valid, input logic [3:0] sel, input logic [31:0] saddr,
                          input int scycles, input logic err, input logic chk_data,
                          input logic [31:0] data, input logic [7:0] ecnt, input int lat);
        int n;
        @(negedge clk);
        wait_cfg = wt;
        if (sel_valid)
            sq.push_back('{sel, w, saddr, wdata, scycles});
        rq.push_back('{err, chk_data, data, ecnt, cyc + 1, lat, name});
        bus.mem_w        = w;
        bus.mem_rd       = r;
        bus.addr_bus     = addr;
        bus.Cpu_data2bus = wdata;
        n = 0;
        while (bus.bus_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no bus_ready expected bus_ready within 40 cycles", name);
        end
        bus.mem_w  = 1'b0;
        bus.mem_rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        int         n;
        rst              = 1'b1;
        bus.mem_w        = 1'b0;
        bus.mem_rd       = 1'b0;
        bus.addr_bus     = '0;
        bus.Cpu_data2bus = '0;
        bus.slv_rdata    = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5678};
        bus_p.mem_w        = 1'b0;
        bus_p.mem_rd       = 1'b0;
        bus_p.addr_bus     = '0;
        bus_p.Cpu_data2bus = '0;
        bus_p.slv_rdata    = '0;
        bus_p.slv_ready    = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_data4bus", bus.Cpu_data4bus, 32'h0);
        check("rst_ready_err", {30'd0, bus.bus_ready, bus.bus_err}, 32'h0);
        check("rst_errcnt", 32'(err_cnt), 32'h0);
        check("rst_sel_we", {27'd0, bus.slv_sel, bus.slv_we}, 32'h0);
        check("rst_slv_addr", bus.slv_addr, 32'h0);
        check("rst_slv_wdata", bus.slv_wdata, 32'h0);

        //      name       w     r     addr          wdata         wt  sv    sel      saddr         cyc err   chk  data          ecnt lat
        access("rd_s0",    1'b0, 1'b1, 32'h0000_0010, 32'h0,        0, 1'b1, 4'b0001, 32'h0000_0010, 1, 1'b0, 1'b1, 32'h1234_5678, 8'd0, 2);
        access("wr_s2",    1'b1, 1'b0, 32'hE000_0004, 32'hCAFE_F00D, 3, 1'b1, 4'b0100, 32'h0000_0004, 4, 1'b0, 1'b1, 32'h1234_5678, 8'd0, 5);
        access("rd_s3",    1'b0, 1'b1, 32'hF000_0020, 32'h0,        1, 1'b1, 4'b1000, 32'h0000_0020, 2, 1'b0, 1'b1, 32'h4444_4444, 8'd0, 3);
        access("wr_miss",  1'b1, 1'b0, 32'h7000_0000, 32'h0000_DEAD, 0, 1'b0, 4'b0000, 32'h0,        0, 1'b1, 1'b1, 32'h4444_4444, 8'd1, 1);
        access("rd_miss",  1'b0, 1'b1, 32'h5000_0000, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        0, 1'b1, 1'b1, 32'h0,        8'd2, 1);
        access("rd_s1",    1'b0, 1'b1, 32'hA000_0100, 32'h0,        2, 1'b1, 4'b0010, 32'h0000_0100, 3, 1'b0, 1'b1, 32'h2222_2222, 8'd2, 4);

        e = 8'd2;
        for (int k = 0; k < 300; k++) begin
            e = (e == 8'd255) ? 8'd255 : e + 8'd1;
            access("rd_tmo", 1'b0, 1'b1, 32'hA000_0100, 32'h0, -1, 1'b1, 4'b0010, 32'h0000_0100, 16,
                   1'b1, 1'b1, 32'h0, e, 17);
        end
        check("errcnt_sat", 32'(err_cnt), 32'd255);

        // Reset two cycles into a waited access: no response, selection dropped at once.
        @(negedge clk);
        wait_cfg = 10;
        sq.push_back('{4'b0001, 1'b0, 32'h0000_0040, 32'h0, 2});
        bus.mem_rd   = 1'b1;
        bus.addr_bus = 32'h0000_0040;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst        = 1'b1;
        bus.mem_rd = 1'b0;
        #1;
        check("rst_mid_sel", 32'(bus.slv_sel), 32'h0);
        check("rst_mid_ready", 32'(bus.bus_ready), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        access("rd_after_rst", 1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b1, 4'b0001, 32'h0, 1, 1'b0, 1'b1, 32'h1234_5678, 8'd0, 2);

        // Overlapping regions with simultaneous read+write on the priority instance.
        @(negedge clk);
        bus_p.mem_w        = 1'b1;
        bus_p.mem_rd       = 1'b1;
        bus_p.addr_bus     = 32'hF000_0000;
        bus_p.Cpu_data2bus = 32'h5A5A_1234;
        n = 0;
        while (bus_p.slv_sel == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("prio_sel", 32'(bus_p.slv_sel), 32'h2);
        check("prio_we", 32'(bus_p.slv_we), 32'h1);
        check("prio_wdata", bus_p.slv_wdata, 32'h5A5A_1234);
        check("prio_addr", bus_p.slv_addr, 32'hF000_0000);
        n = 0;
        while (bus_p.bus_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("prio_ready", 32'(bus_p.bus_ready), 32'h1);
        check("prio_err", {23'd0, bus_p.bus_err, err_cnt_p}, 32'h0);
        bus_p.mem_w  = 1'b0;
        bus_p.mem_rd = 1'b0;

        repeat (5) @(negedge clk);
        check("rsp_queue_empty", 32'(rq.size()), 32'h0);
        check("slv_queue_empty", 32'(sq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mio_bus_bridge.md
Name: mio_bus_bridge

Overview:
- Parametrised, registered memory-mapped I/O bridge between the CPU data port and N_SLV peripheral/memory slaves.
- Each slave region is decoded by base and mask.
- Each access runs through a request/ready handshake with per-access wait states, a timeout, and a bus-error response.
- Replaces purely combinational decode; sits between the CPU data-memory interface and RAM, VGA, 7-seg, and GPIO/counter devices.

Parameters:
- N_SLV, 4: number of slave regions.
- AW, 32: address width.
- DW, 32: data width.
- SLV_BASE, {32'hF0000000,32'hE0000000,32'hA0000000,32'h00000000}: packed N_SLV*AW bases; slave 0 occupies the LSBs.
- SLV_MASK, {4{32'hF0000000}}: packed N_SLV*AW masks; 1 = bit compared.
- TIMEOUT, 15: maximum ACCESS cycles before a bus error (1..2^TO_W-1).
- TO_W, 4: timeout counter width.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- mem_w, in, 1: CPU write request; held until bus_ready.
- mem_rd, in, 1: CPU read request; held until bus_ready.
- addr_bus, in, AW: CPU address.
- Cpu_data2bus, in, DW: CPU write data.
- Cpu_data4bus, out, DW: registered read data to CPU.
- bus_ready, out, 1: one-cycle completion strobe.
- bus_err, out, 1: error qualifier, valid with bus_ready.
- err_cnt, out, 8: saturating count of bus errors.
- slv_sel, out, N_SLV: one-hot slave select.
- slv_we, out, 1: write strobe for the selected slave.
- slv_addr, out, AW: offset within region (addr & ~MASK).
- slv_wdata, out, DW: latched write data.
- slv_rdata, in, N_SLV*DW: packed slave read data.
- slv_ready, in, N_SLV: slave completion.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE.
  - All outputs 0: Cpu_data4bus, bus_ready, bus_err, err_cnt, slv_sel, slv_we, slv_addr, slv_wdata.
  - Timeout counter 0.
- Reset during ACCESS drops slv_sel the same instant; the transaction is discarded with no response.
- State machine (IDLE, ACCESS, RESP):
  - IDLE:
    - If mem_w|mem_rd is sampled high, latch addr_bus, Cpu_data2bus, and the direction.
    - If both mem_w and mem_rd are high, the access is a write.
    - Decode: the hit is the lowest index i with (addr_bus & MASK_i) == BASE_i; overlapping regions resolve to the lower index.
    - Hit: register slv_sel=onehot(i), slv_we=write, slv_addr, slv_wdata; go to ACCESS; clear the timeout counter.
    - Miss: go to RESP with err=1; no slave is selected.
  - ACCESS:
    - slv_sel and slv_we are held stable.
    - Each cycle in which slv_ready[i] for the selected slave is low, the timeout counter increments.
    - slv_ready[i] high: on a read, capture slv_rdata[i] into Cpu_data4bus. Drop slv_sel and slv_we. Go to RESP with err=0.
    - Counter reaches TIMEOUT with ready still low: drop slv_sel and slv_we; go to RESP with err=1.
    - slv_ready of unselected slaves is ignored.
  - RESP:
    - bus_ready=1 for exactly one cycle; bus_err=err.
    - On err, err_cnt increments, saturating at 255.
    - On a read with err, Cpu_data4bus is 0.
    - Go to IDLE unconditionally; a held request is not re-accepted until IDLE.
- Cpu_data4bus holds its last value across writes and idle cycles.
- Latency:
  - Request sampled at edge N, slave ready in the first ACCESS cycle: bus_ready high during cycle N+2.
  - Each extra wait cycle adds 1.
  - Timeout gives bus_ready in cycle N+TIMEOUT+2.
- The CPU must keep mem_w/mem_rd high until bus_ready. The request must be deasserted in the cycle after bus_ready to avoid a repeat access. Request changes mid-transaction are ignored, since everything is latched.

Decomposition:
- Shared package mio_pkg:
  - state enum (IDLE/ACCESS/RESP).
  - Region constants: RAM_BASE=0x00000000, GFX_BASE=0xA0000000, SEG_BASE=0xE0000000, GPIO_BASE=0xF0000000, REGION_MASK=0xF0000000.
  - ERR_CNT_W=8.
- One natural sub-module, mio_addr_decode: combinational priority base/mask decoder that outputs a hit flag and a one-hot vector, parametrised by N_SLV/AW.

Test Plan:
- Read, slave 0 ready in the first ACCESS cycle:
  - Stimulus: mem_rd=1, addr=0x00000010, slv_rdata[0]=0x12345678.
  - Response: slv_sel=0001, slv_addr=0x10, bus_ready 2 cycles after request, Cpu_data4bus=0x12345678, bus_err=0.
- Write with wait states:
  - Stimulus: mem_w=1, addr=0xE0000004, data=0xCAFEF00D; slave 2 ready after 3 cycles.
  - Response: slv_sel=0100, slv_we=1, slv_wdata=0xCAFEF00D held 4 cycles, bus_ready at request+5.
- Unmapped address:
  - Stimulus: mem_rd at 0x50000000.
  - Response: no slv_sel, bus_ready+bus_err at request+1, Cpu_data4bus=0, err_cnt=1.
- Timeout:
  - Stimulus: mem_rd at 0xA0000100; slave 1 never ready.
  - Response: bus_err with bus_ready at request+17 (TIMEOUT=15), slv_sel low after timeout; 300 such accesses give err_cnt=255.
- Priority and simultaneous requests:
  - Stimulus: SLV_MASK[1]=0 (matches all), addr=0xF0000000, mem_w=mem_rd=1.
  - Response: slave 1 selected, write performed.
- Reset mid-ACCESS:
  - Stimulus: assert rst two cycles into a waited access.
  - Response: slv_sel=0, bus_ready never pulses; after release a new read at 0x0 completes normally.
